// File: rtl/branch_sched.sv
// ---------------------------------------------------------------------------
// branch_sched -- decode-stage branch scheduler for the MIPS pipeline.
//
// Sits beside the decode-stage branch comparator. It stalls fetch/decode
// until the comparator operands are valid, selects the decode-stage
// forwarding source for each operand and qualifies the raw comparator result
// into the branch-taken signal that steers the PC.
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   branchD, use_rtD            decode instruction is a branch / compares rt
//   rsD, rtD                    branch source registers
//   regwriteE/memtoregE/writeregE   execute-stage producer
//   regwriteM/memtoregM/writeregM   memory-stage producer
//   pcsrc_rawD                  raw comparator result
//   stall_ext, flushD           external freeze, decode flush
//   forwardaD, forwardbD        1 = take memory-stage ALU result
//   stallF, stallD, flushE      pipeline control
//   branch_takenD               qualified branch-taken
//   stat_branches/taken/stalls  statistics counters
//
// Configuration macro: BRANCH_STATS_EN builds the saturating statistics
// counters; when undefined the stat outputs are tied to zero.
// ---------------------------------------------------------------------------
module branch_sched #(
  parameter int REG_AW = 5,
  parameter int DW     = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              branchD,
  input  logic              use_rtD,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              regwriteE,
  input  logic              memtoregE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic              regwriteM,
  input  logic              memtoregM,
  input  logic [REG_AW-1:0] writeregM,
  input  logic              pcsrc_rawD,
  input  logic              stall_ext,
  input  logic              flushD,
  output logic              forwardaD,
  output logic              forwardbD,
  output logic              stallF,
  output logic              stallD,
  output logic              flushE,
  output logic              branch_takenD,
  output logic [DW-1:0]     stat_branches,
  output logic [DW-1:0]     stat_taken,
  output logic [DW-1:0]     stat_stalls
);

  typedef enum logic [1:0] {IDLE = 2'd0, STALL = 2'd1, GO = 2'd2} state_e;

  state_e     state_q;
  logic [1:0] cnt_q;

  // Per-operand hazard/forwarding terms; index 0 = rs, 1 = rt.
  logic [REG_AW-1:0] src     [2];
  logic [1:0]        src_en;
  logic [1:0]        hit_e;
  logic [1:0]        hit_m;
  logic [1:0]        fwd;

  assign src[0]    = rsD;
  assign src[1]    = rtD;
  assign src_en[0] = 1'b1;
  assign src_en[1] = use_rtD;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      logic nonzero;
      assign nonzero   = (src[gi] != '0);
      assign hit_e[gi] = src_en[gi] & nonzero & regwriteE & (writeregE == src[gi]);
      assign hit_m[gi] = src_en[gi] & nonzero & regwriteM & (writeregM == src[gi]);
      // Forwarding is evaluated regardless of use_rtD.
      assign fwd[gi]   = nonzero & regwriteM & ~memtoregM & (writeregM == src[gi]);
    end
  endgenerate

  assign forwardaD = fwd[0];
  assign forwardbD = fwd[1];

  // Required stall count: E load 2, E ALU or M load 1, M ALU 0 (forwarded).
  logic       need_two;
  logic       need_one;
  logic [1:0] need_n;

  assign need_two = (|hit_e) & memtoregE;
  assign need_one = ((|hit_e) & ~memtoregE) | ((|hit_m) & memtoregM);
  assign need_n   = need_two ? 2'd2 : (need_one ? 2'd1 : 2'd0);

  logic detect;
  logic hz;
  logic resolve;

  assign detect  = (state_q == IDLE) & branchD & (need_n != 2'd0);
  assign hz      = detect | (state_q == STALL);
  assign resolve = branchD & ~hz & ~flushD;

  assign stallF        = hz | stall_ext;
  assign stallD        = hz | stall_ext;
  assign flushE        = hz & ~stall_ext;
  assign branch_takenD = branchD & pcsrc_rawD & ~hz & ~stall_ext & ~flushD;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else if (flushD) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          // Under stall_ext nothing is loaded; detection simply repeats.
          if (detect && !stall_ext) begin
            if (need_n == 2'd2) begin
              state_q <= STALL;
              cnt_q   <= 2'd1;
            end else begin
              state_q <= GO;
            end
          end
        end
        STALL: begin
          if (!stall_ext) begin
            cnt_q <= cnt_q - 2'd1;
            if (cnt_q == 2'd1) state_q <= GO;
          end
        end
        GO: begin
          if (!stall_ext) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 2'd0;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  // Counter 0 = resolving branches, 1 = taken, 2 = hazard-stall cycles.
  logic [DW-1:0] stat_q [3];
  logic [2:0]    stat_inc;

  assign stat_inc = {hz, branch_takenD, resolve};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          stat_q[gi] <= '0;
        end else if (!stall_ext && stat_inc[gi] && (stat_q[gi] != '1)) begin
          stat_q[gi] <= stat_q[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign stat_branches = stat_q[0];
  assign stat_taken    = stat_q[1];
  assign stat_stalls   = stat_q[2];
`else
  logic unused_resolve;
  assign unused_resolve = resolve;
  assign stat_branches  = '0;
  assign stat_taken     = '0;
  assign stat_stalls    = '0;
`endif

endmodule

// File: tb/tb_branch_sched.sv
// ---------------------------------------------------------------------------
// tb_branch_sched -- randomized scoreboard bench for branch_sched.
//
// The stimulus process drives random inputs once per cycle, computes the
// expected outputs from a count-based reference model (a pending branch with
// "cycles needed" / "cycles served") and pushes them into a queue. A
// separate monitor pops one entry per cycle on the falling edge and compares.
// ---------------------------------------------------------------------------
module tb_branch_sched;

  localparam int REG_AW = 5;
  localparam int DW     = 32;
  localparam int NCYC   = 4000;

  logic              clk;
  logic              resetn;
  logic              branchD, use_rtD;
  logic [REG_AW-1:0] rsD, rtD, writeregE, writeregM;
  logic              regwriteE, memtoregE, regwriteM, memtoregM;
  logic              pcsrc_rawD, stall_ext, flushD;
  logic              forwardaD, forwardbD, stallF, stallD, flushE, branch_takenD;
  logic [DW-1:0]     stat_branches, stat_taken, stat_stalls;

  branch_sched #(.REG_AW(REG_AW), .DW(DW)) dut (
    .clk(clk), .resetn(resetn),
    .branchD(branchD), .use_rtD(use_rtD), .rsD(rsD), .rtD(rtD),
    .regwriteE(regwriteE), .memtoregE(memtoregE), .writeregE(writeregE),
    .regwriteM(regwriteM), .memtoregM(memtoregM), .writeregM(writeregM),
    .pcsrc_rawD(pcsrc_rawD), .stall_ext(stall_ext), .flushD(flushD),
    .forwardaD(forwardaD), .forwardbD(forwardbD),
    .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .branch_takenD(branch_takenD),
    .stat_branches(stat_branches), .stat_taken(stat_taken), .stat_stalls(stat_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        fa, fb, stl, fle, bt, res, ext;
    logic [31:0] sb, st, ss;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_txn  = 0;

  // Reference model state: a branch that has begun stalling is "active"; it
  // needs m_need non-frozen stall cycles and has served m_served of them.
  bit          m_active;
  int          m_need, m_served, m_n;
  bit          m_hz, m_bt, m_res;
  logic [31:0] m_sb, m_st, m_ss;

  task automatic check(input string name, input int cyc,
                       input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic bit dep(input logic [REG_AW-1:0] s, input logic [REG_AW-1:0] w,
                             input logic we);
    return (s != 0) && we && (w == s);
  endfunction

  task automatic model_clear();
    m_active = 0; m_need = 0; m_served = 0;
    m_sb = 0; m_st = 0; m_ss = 0;
  endtask

  // Required stall count from the current producers: max over all hazards.
  task automatic model_need(output int n);
    n = 0;
    for (int k = 0; k < 2; k++) begin
      logic [REG_AW-1:0] s;
      s = (k == 0) ? rsD : rtD;
      if (k == 0 || use_rtD) begin
        if (dep(s, writeregE, regwriteE)) n = max2(n, memtoregE ? 2 : 1);
        if (dep(s, writeregM, regwriteM) && memtoregM) n = max2(n, 1);
      end
    end
  endtask

  // Advance the model across a rising edge, using the inputs of the cycle
  // that just ended (still on the pins at this point).
  task automatic model_commit();
    if (!resetn) begin
      model_clear();
    end else begin
      if (!stall_ext) begin
        m_sb += m_res ? 1 : 0;
        m_st += m_bt ? 1 : 0;
        m_ss += m_hz ? 1 : 0;
      end
      if (flushD) begin
        m_active = 0;
      end else if (!m_active) begin
        if (m_hz && !stall_ext) begin
          m_active = 1; m_need = m_n; m_served = 1;
        end
      end else if (!stall_ext) begin
        if (m_served < m_need) m_served++;
        else m_active = 0;
      end
    end
  endtask

  initial begin
    exp_t e;
    resetn = 0; branchD = 0; use_rtD = 0; rsD = 0; rtD = 0;
    regwriteE = 0; memtoregE = 0; writeregE = 0;
    regwriteM = 0; memtoregM = 0; writeregM = 0;
    pcsrc_rawD = 0; stall_ext = 0; flushD = 0;
    model_clear();
    m_hz = 0; m_bt = 0; m_res = 0; m_n = 0;

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk); #1;
      model_commit();

      resetn     = (c < 3) ? 1'b0 : ($urandom_range(0, 299) != 0);
      branchD    = ($urandom_range(0, 9) < 7);
      use_rtD    = $urandom_range(0, 1);
      rsD        = REG_AW'($urandom_range(0, 3));
      rtD        = REG_AW'($urandom_range(0, 3));
      regwriteE  = ($urandom_range(0, 3) != 0);
      memtoregE  = $urandom_range(0, 1);
      writeregE  = REG_AW'($urandom_range(0, 3));
      regwriteM  = ($urandom_range(0, 3) != 0);
      memtoregM  = $urandom_range(0, 1);
      writeregM  = REG_AW'($urandom_range(0, 3));
      pcsrc_rawD = $urandom_range(0, 1);
      stall_ext  = ($urandom_range(0, 4) == 0);
      flushD     = ($urandom_range(0, 19) == 0);

      if (!resetn) model_clear();  // asynchronous reset acts immediately

      model_need(m_n);
      m_hz  = m_active ? (m_served < m_need) : (branchD && (m_n > 0));
      m_bt  = branchD && pcsrc_rawD && !m_hz && !stall_ext && !flushD;
      m_res = branchD && !m_hz && !flushD;

      e.cyc = c;
      e.fa  = dep(rsD, writeregM, regwriteM) && !memtoregM;
      e.fb  = dep(rtD, writeregM, regwriteM) && !memtoregM;
      e.stl = m_hz || stall_ext;
      e.fle = m_hz && !stall_ext;
      e.bt  = m_bt;
      e.res = m_res;
      e.ext = stall_ext;
`ifdef BRANCH_STATS_EN
      e.sb = m_sb; e.st = m_st; e.ss = m_ss;
`else
      e.sb = 0; e.st = 0; e.ss = 0;
`endif
      q.push_back(e);
    end

    @(posedge clk); #1;
    check("queue_drained", NCYC, q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Monitor: the DUT presents its outputs every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("forwardaD", e.cyc, 32'(forwardaD), 32'(e.fa));
        check("forwardbD", e.cyc, 32'(forwardbD), 32'(e.fb));
        check("stallF", e.cyc, 32'(stallF), 32'(e.stl));
        check("stallD", e.cyc, 32'(stallD), 32'(e.stl));
        check("flushE", e.cyc, 32'(flushE), 32'(e.fle));
        check("branch_takenD", e.cyc, 32'(branch_takenD), 32'(e.bt));
        check("stat_branches", e.cyc, stat_branches, e.sb);
        check("stat_taken", e.cyc, stat_taken, e.st);
        check("stat_stalls", e.cyc, stat_stalls, e.ss);
        if (e.res && !e.ext) begin
          n_txn++;
          $display("txn %0d: cyc %0d branch resolved taken=%0b", n_txn, e.cyc, e.bt);
        end
      end
    end
  end

endmodule

// File: doc/branch_sched.md
# branch_sched

Decode-stage branch scheduler for the MIPS pipeline. It sits beside the decode-stage branch comparator and checks that the comparator's operands are valid before its result is used. It detects read-after-write hazards on the branch source registers and stalls fetch and decode for the required number of cycles. It also selects the decode-stage forwarding source for each operand and qualifies the raw comparator output into the branch-taken signal that steers the PC.

## Interface
Parameters
- REG_AW, 5: register index width.
- DW, 32: statistics counter width.

Ports
- clk  in  1  pipeline clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- branchD  in  1  decode instruction is a conditional branch.
- use_rtD  in  1  branch compares rt (EQ/NEQ); 0 means rs only (GTZ/GEZ/LTZ/LEZ).
- rsD, rtD  in  REG_AW  branch source registers.
- regwriteE, memtoregE  in  1  control bits of the execute-stage instruction.
- writeregE  in  REG_AW  destination register of the execute-stage instruction.
- regwriteM, memtoregM  in  1  control bits of the memory-stage instruction.
- writeregM  in  REG_AW  destination register of the memory-stage instruction.
- pcsrc_rawD  in  1  raw comparator result.
- stall_ext  in  1  external pipeline freeze (divider or cache).
- flushD  in  1  exception flush of decode.
- forwardaD, forwardbD  out  1  operand source: 0 = register file, 1 = memory-stage ALU result.
- stallF, stallD  out  1  hold the fetch and decode registers.
- flushE  out  1  insert a bubble into execute.
- branch_takenD  out  1  qualified branch-taken signal to the PC mux.
- stat_branches, stat_taken, stat_stalls  out  DW  statistics counters (see Configuration).

## Operation
- A hazard exists on source register s when s != 0 and s matches a writing producer in E or M. The rt operand counts only when use_rtD=1.
- Required stall count N is the maximum over all hazards:
  - E-stage ALU producer (regwriteE & ~memtoregE): 1.
  - E-stage load (regwriteE & memtoregE): 2.
  - M-stage load: 1.
  - M-stage ALU producer: 0, resolved by forwarding.
- State machine with states IDLE, STALL and GO. A cnt register (2 bits) tracks remaining stall cycles.
  - IDLE, branchD & N>0 & ~stall_ext: stall this cycle. N=1 goes to GO. N=2 goes to STALL with cnt=1.
  - IDLE, stall_ext: no transition and nothing is loaded; detection repeats next cycle.
  - STALL: stall. When ~stall_ext, decrement cnt, and cnt reaching 0 goes to GO. When stall_ext, cnt holds.
  - GO: hazard detection is suppressed and the branch resolves. ~stall_ext goes to IDLE; stall_ext holds GO.
  - flushD in any state: next state IDLE, cnt=0. flushD overrides every other transition.
- The hazard stall signal hz is the IDLE detection condition OR (state==STALL).
- stallF = stallD = hz | stall_ext.
- flushE = hz & ~stall_ext.
- forwardaD = (rsD!=0) & regwriteM & ~memtoregM & (writeregM==rsD). forwardbD is the same test on rtD. Both are combinational and evaluated in every state.
- branch_takenD = branchD & pcsrc_rawD & ~hz & ~stall_ext & ~flushD.
- A branch with no hazard resolves in IDLE with zero added cycles.
- The delay-slot instruction is never flushed by this block.

## Timing
- Reset: state=IDLE, cnt=0, all statistics counters 0. All combinational outputs follow from state IDLE with the current inputs.
- Added latency: exactly N cycles (0, 1 or 2), plus the number of cycles stall_ext is asserted.
- branch_takenD is combinational and is valid in the resolving cycle, which is either IDLE with no hazard or GO.
- Reset asserted mid-stall aborts immediately; no partial counts are retained.

## Configuration
- BRANCH_STATS_EN defined: three saturating counters, each incrementing on a cycle with ~stall_ext.
  - stat_branches +1 per resolving branch cycle.
  - stat_taken +1 when branch_takenD=1.
  - stat_stalls +1 per hz cycle.
  - All three clear on reset.
- BRANCH_STATS_EN undefined: no counter registers are built, and the three stat outputs are tied to 0.

## Test plan
- No hazard: branchD=1, rsD=3, no producers, pcsrc_rawD=1 -> branch_takenD=1 the same cycle, stallD never asserted.
- E-stage ALU producer writing rs=5 -> stallD=1 for 1 cycle, then GO with forwardaD=1 and branch_takenD=pcsrc_rawD.
- E-stage load writing rt=7, use_rtD=1 -> stallD for 2 cycles and flushE for 2 cycles, then resolve; with use_rtD=0 -> 0 stalls.
- E-stage load hazard with stall_ext pulsed 3 cycles mid-STALL -> total stall is 5 cycles, flushE=0 during stall_ext, cnt held.
- flushD asserted in STALL -> next cycle IDLE, branch_takenD=0. Writer to $0 -> never stalls.
- With BRANCH_STATS_EN: 4 branches, 3 taken, 1 E-stage load hazard -> stat_branches=4, stat_taken=3, stat_stalls=2.
